// File: rtl/vert_transform.sv
// Rotating-model vertex stage: free-running Y-axis angle plus a per-pass
// fetch / rotate / emit pipeline feeding screen coordinates to a valid/ready stream.
`timescale 1ns/1ps
module vert_transform #(
   parameter int NUM_VERTS   = 3,
   parameter int COORD_W     = 8,
   parameter int TRIG_W      = 11,
   parameter int FRAME_TICKS = 333334,
   parameter int ANGLE_MAX   = 359,
   parameter int CENTER_X    = 320,
   parameter int CENTER_Y    = 120,
   parameter int IDX_W       = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1
) (
   input  logic                      clk_pix,
   input  logic                      resetn,
   input  logic                      pause,
   input  logic                      dir,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [8:0]                angle,
   output logic [8:0]                trig_angle,
   input  logic signed [TRIG_W-1:0]  sin,
   input  logic signed [TRIG_W-1:0]  cos,
   output logic [IDX_W-1:0]          vtx_addr,
   input  logic signed [COORD_W-1:0] vtx_x,
   input  logic signed [COORD_W-1:0] vtx_y,
   input  logic signed [COORD_W-1:0] vtx_z,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [IDX_W-1:0]          out_idx,
   output logic [9:0]                out_x,
   output logic [8:0]                out_y,
   output logic signed [COORD_W:0]   out_z
);
   localparam int FRAC   = TRIG_W - 1;
   localparam int PW     = COORD_W + TRIG_W + 1;
   localparam int TICK_W = $clog2(FRAME_TICKS);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);
   localparam logic [8:0]        ANG_LAST  = 9'(ANGLE_MAX);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VERTS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MUL, S_EMIT} state_t;
   state_t state_q, state_d;

   logic [TICK_W-1:0]  tick;
   logic               last_vtx;
   logic signed [PW-1:0] xe, ze, se, ce, xp, zp;

   // angle stepper: tick and angle both freeze while paused
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         tick  <= '0;
         angle <= '0;
      end else if (!pause) begin
         if (tick == TICK_LAST) begin
            tick <= '0;
            if (dir) angle <= (angle == 9'd0) ? ANG_LAST : angle - 9'd1;
            else     angle <= (angle == ANG_LAST) ? 9'd0 : angle + 9'd1;
         end else begin
            tick <= tick + TICK_W'(1);
         end
      end
   end

   assign last_vtx = (vtx_addr == IDX_LAST);

   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b1;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_MUL;
         S_MUL:   state_d = S_EMIT;
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done    = last_vtx;
               state_d = last_vtx ? S_IDLE : S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // widened operands keep the sum of two products exact
   assign xe = PW'(vtx_x);
   assign ze = PW'(vtx_z);
   assign se = PW'(sin);
   assign ce = PW'(cos);
   assign xp = xe * ce + ze * se;
   assign zp = ze * ce - xe * se;

   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         trig_angle <= '0;
         vtx_addr   <= '0;
         out_idx    <= '0;
         out_x      <= '0;
         out_y      <= '0;
         out_z      <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            trig_angle <= angle;
            vtx_addr   <= '0;
         end
         if (state_q == S_MUL) begin
            out_idx <= vtx_addr;
            out_x   <= 10'(xp >>> FRAC) + 10'(CENTER_X);
            out_y   <= 9'(vtx_y) + 9'(CENTER_Y);
            out_z   <= (COORD_W+1)'(zp >>> FRAC);
         end
         if (state_q == S_EMIT && out_ready && !last_vtx)
            vtx_addr <= vtx_addr + IDX_W'(1);
      end
   end
endmodule

// File: tb/tb_vert_transform.sv
// Directed bench for vert_transform: vertex/trig ROM models, table-driven passes,
// plus stall, angle-stepping, start-while-busy and mid-pass reset sequences.
`timescale 1ns/1ps
module tb_vert_transform;
   localparam int NV = 3;
   localparam int CW = 8;
   localparam int TW = 11;

   logic clk_pix = 1'b0, resetn = 1'b0, pause = 1'b1, dir = 1'b0, start = 1'b0, out_ready = 1'b1;
   logic busy, done, out_valid;
   logic [8:0] angle, trig_angle;
   logic signed [TW-1:0] sin, cos;
   logic [1:0] vtx_addr, out_idx;
   logic signed [CW-1:0] vtx_x, vtx_y, vtx_z;
   logic [9:0] out_x;
   logic [8:0] out_y;
   logic signed [CW:0] out_z;

   vert_transform #(.NUM_VERTS(NV), .COORD_W(CW), .TRIG_W(TW), .FRAME_TICKS(4),
                    .ANGLE_MAX(359), .CENTER_X(320), .CENTER_Y(120)) dut (
      .clk_pix(clk_pix), .resetn(resetn), .pause(pause), .dir(dir), .start(start),
      .busy(busy), .done(done), .angle(angle), .trig_angle(trig_angle),
      .sin(sin), .cos(cos), .vtx_addr(vtx_addr), .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_x(out_x), .out_y(out_y), .out_z(out_z));

   always #5 clk_pix = ~clk_pix;

   // ROM models, one-cycle read latency
   logic signed [CW-1:0] rx[4], ry[4], rz[4];
   logic signed [TW-1:0] sin_v = '0, cos_v = '0;
   always @(posedge clk_pix) begin
      vtx_x <= rx[vtx_addr];
      vtx_y <= ry[vtx_addr];
      vtx_z <= rz[vtx_addr];
      sin   <= sin_v;
      cos   <= cos_v;
   end

   typedef struct { int x, y, z, ex, ey, ez; } vec_t;
   vec_t vt[9];
   int ps[3], pc[3];
   int ncmp = 0, nerr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic load(input int p);
      for (int k = 0; k < 4; k++) begin
         rx[k] = (k < NV) ? CW'(vt[p*NV+k].x) : '0;
         ry[k] = (k < NV) ? CW'(vt[p*NV+k].y) : '0;
         rz[k] = (k < NV) ? CW'(vt[p*NV+k].z) : '0;
      end
      sin_v = TW'(ps[p]);
      cos_v = TW'(pc[p]);
   endtask

   task automatic check_vtx(input int p, input int k);
      chk("out_idx", out_idx, k);
      chk("out_x", out_x, vt[p*NV+k].ex);
      chk("out_y", out_y, vt[p*NV+k].ey);
      chk("out_z", out_z, vt[p*NV+k].ez);
   endtask

   // entered just after a negedge; stall holds vertex 0 for 5 cycles, hold keeps start high
   task automatic run_pass(input int p, input bit stall, input bit hold);
      int cyc;
      load(p);
      out_ready = !stall;
      start = 1'b1;
      for (int k = 0; k < NV; k++) begin
         cyc = 0;
         do begin
            @(negedge clk_pix);
            cyc++;
            if (k == 0 && cyc == 1) begin
               chk("busy_set", busy, 1);
               if (!hold) start = 1'b0;
            end
         end while (!out_valid && cyc < 12);
         chk("vtx_latency", cyc, 3);
         if (k == 0 && stall) begin
            for (int s = 0; s < 5; s++) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_x", out_x, vt[p*NV].ex);
               chk("stall_addr", vtx_addr, 0);
               chk("stall_done", done, 0);
               @(negedge clk_pix);
            end
            out_ready = 1'b1;
         end
         check_vtx(p, k);
         chk("done", done, (k == NV-1) ? 1 : 0);
         if (k == NV-1) start = 1'b0;
      end
      @(negedge clk_pix);
      chk("busy_end", busy, 0);
      chk("valid_end", out_valid, 0);
      chk("done_end", done, 0);
   endtask

   task automatic step_chk(input int old_a, input int new_a);
      repeat (3) @(negedge clk_pix);
      chk("angle_hold", angle, old_a);
      @(negedge clk_pix);
      chk("angle_step", angle, new_a);
   endtask

   initial begin
      int cyc;
      ps[0] = 0;    pc[0] = 1023;
      ps[1] = 1023; pc[1] = 0;
      ps[2] = -724; pc[2] = 724;
      vt[0] = '{100, 20, 0, 419, 140, 0};
      vt[1] = '{-50, -10, 30, 270, 110, 29};
      vt[2] = '{127, 127, -128, 446, 247, -128};
      vt[3] = '{0, 0, 100, 419, 120, 0};
      vt[4] = '{-100, 0, 0, 320, 120, 99};
      vt[5] = '{100, -120, 0, 320, 0, -100};
      vt[6] = '{100, -128, 100, 320, 504, 141};
      vt[7] = '{10, 5, -20, 341, 125, -8};
      vt[8] = '{0, 0, 0, 320, 120, 0};
      load(0);

      repeat (2) @(negedge clk_pix);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_angle", angle, 0);
      chk("rst_trig", trig_angle, 0);
      chk("rst_addr", vtx_addr, 0);
      chk("rst_out_x", out_x, 0);
      resetn = 1'b1;
      @(negedge clk_pix);

      // rotation table, angle held at 0
      for (int p = 0; p < 3; p++) run_pass(p, 1'b0, 1'b0);
      chk("trig_zero", trig_angle, 0);

      // downstream stall
      run_pass(0, 1'b1, 1'b0);

      // angle stepping with FRAME_TICKS=4
      dir = 1'b1; pause = 1'b0;
      cyc = 0;
      do begin @(negedge clk_pix); cyc++; end while (angle == 9'd0 && cyc < 10);
      chk("angle_wrap_down", angle, 359);
      chk("angle_first_step_cyc", cyc, 4);
      step_chk(359, 358);
      dir = 1'b0;
      step_chk(358, 359);
      step_chk(359, 0);
      step_chk(0, 1);
      pause = 1'b1;
      repeat (20) @(negedge clk_pix);
      chk("angle_paused", angle, 1);

      // start held through a pass; angle moves but trig_angle stays latched
      pause = 1'b0;
      run_pass(2, 1'b0, 1'b1);
      chk("trig_latched", trig_angle, 1);
      chk("angle_moved", angle, 3);
      run_pass(1, 1'b0, 1'b0);
      chk("trig_relatch", trig_angle, 3);

      // reset in the middle of EMIT
      load(0);
      out_ready = 1'b0;
      start = 1'b1;
      cyc = 0;
      do begin @(negedge clk_pix); cyc++; start = 1'b0; end while (!out_valid && cyc < 12);
      chk("pre_rst_valid", out_valid, 1);
      resetn = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_done", done, 0);
      chk("arst_angle", angle, 0);
      chk("arst_out_x", out_x, 0);
      @(negedge clk_pix);
      resetn = 1'b1;
      pause = 1'b1;
      @(negedge clk_pix);
      run_pass(0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
